// File: rtl/ec_fp_mult_arbiter_if.sv
// Valid/ready stream bundle used on every port of ec_fp_mult_arbiter.
// sop/eop/err/mod ride along for compatibility with other stream blocks.
interface ec_fp_mult_arbiter_if #(
  parameter int unsigned DAT_BITS = 8,
  parameter int unsigned CTL_BITS = 8,
  parameter int unsigned MOD_BITS = 1
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic [MOD_BITS-1:0] mod;

  modport master (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport slave  (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/ec_fp_mult_arbiter.sv
// Round-robin sharing of one modular multiplier between NUM_REQ EC units, with
// tagged requests, tag-routed responses and per-requester in-flight limits.
module ec_fp_mult_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned DAT_BITS = 381,
  parameter int unsigned CTL_BITS = 8,
  parameter int unsigned MAX_OUT  = 8,
  localparam int unsigned TAG_BITS = $clog2(NUM_REQ)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  ec_fp_mult_arbiter_if.slave  i_req_if [NUM_REQ],
  ec_fp_mult_arbiter_if.master o_rsp_if [NUM_REQ],
  ec_fp_mult_arbiter_if.master o_mult_if,
  ec_fp_mult_arbiter_if.slave  i_mult_if,
  output logic                 o_idle,
  output logic                 o_err
);

  localparam int unsigned CNT_BITS = 8;
  localparam logic [CNT_BITS-1:0] CntOne = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CntMax = CNT_BITS'(MAX_OUT);
  localparam logic [TAG_BITS:0] NumReqW = (TAG_BITS + 1)'(NUM_REQ);

  typedef logic [TAG_BITS-1:0] tag_t;

  // Requester-side views of the interface arrays.
  logic [NUM_REQ-1:0]    req_val;
  logic [NUM_REQ-1:0]    req_rdy;
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    rsp_rdy;
  logic [NUM_REQ-1:0]    rsp_val;
  logic [2*DAT_BITS-1:0] req_dat [NUM_REQ];
  logic [CTL_BITS-1:0]   req_ctl [NUM_REQ];
  logic [NUM_REQ-1:0]    unused_req_side;
  logic                  unused_mult_side;

  // State.
  logic                         mult_val_q, mult_val_d;
  logic [2*DAT_BITS-1:0]        mult_dat_q, mult_dat_d;
  logic [CTL_BITS+TAG_BITS-1:0] mult_ctl_q, mult_ctl_d;
  logic                         rsp_val_q, rsp_val_d;
  tag_t                         rsp_tag_q, rsp_tag_d;
  logic [DAT_BITS-1:0]          rsp_dat_q, rsp_dat_d;
  logic [CTL_BITS-1:0]          rsp_ctl_q, rsp_ctl_d;
  tag_t                         rr_ptr_q, rr_ptr_d;
  logic [CNT_BITS-1:0]          cnt_q [NUM_REQ];
  logic [CNT_BITS-1:0]          cnt_d [NUM_REQ];
  logic                         err_q, err_d;
  logic                         idle_q, idle_d;

  // Control.
  logic out_free;
  logic grant_val;
  tag_t grant_idx;
  logic accept;
  tag_t mult_in_tag;
  logic tag_ok;
  logic mult_in_rdy;
  logic mult_fire;
  logic rsp_taken;
  logic cnt_zero;

  function automatic tag_t wrap_add(tag_t base, int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return tag_t'(sum);
  endfunction

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_port
    assign req_val[k] = i_req_if[k].val;
    assign req_dat[k] = i_req_if[k].dat[2*DAT_BITS-1:0];
    assign req_ctl[k] = i_req_if[k].ctl[CTL_BITS-1:0];
    assign i_req_if[k].rdy = req_rdy[k];
    assign unused_req_side[k] = ^{i_req_if[k].sop, i_req_if[k].eop, i_req_if[k].err,
                                  i_req_if[k].mod};
    assign elig[k] = req_val[k] & (cnt_q[k] < CntMax);

    assign rsp_rdy[k]       = o_rsp_if[k].rdy;
    assign rsp_val[k]       = rsp_val_q & (rsp_tag_q == TAG_BITS'(k));
    assign o_rsp_if[k].val  = rsp_val[k];
    assign o_rsp_if[k].dat  = rsp_dat_q;
    assign o_rsp_if[k].ctl  = rsp_ctl_q;
    assign o_rsp_if[k].sop  = 1'b1;
    assign o_rsp_if[k].eop  = 1'b1;
    assign o_rsp_if[k].err  = 1'b0;
    assign o_rsp_if[k].mod  = '0;
  end

  assign unused_mult_side = ^{i_mult_if.sop, i_mult_if.eop, i_mult_if.err, i_mult_if.mod,
                              i_mult_if.ctl};

  assign out_free    = ~mult_val_q | o_mult_if.rdy;
  assign accept      = out_free & grant_val;
  assign mult_in_tag = i_mult_if.ctl[CTL_BITS +: TAG_BITS];
  assign tag_ok      = {1'b0, mult_in_tag} < NumReqW;
  assign rsp_taken   = rsp_val_q & rsp_rdy[rsp_tag_q];
  assign mult_in_rdy = ~rsp_val_q | rsp_taken;
  assign mult_fire   = i_mult_if.val & mult_in_rdy;

  // Descending scan so the smallest offset from rr_ptr wins.
  always_comb begin
    grant_val = 1'b0;
    grant_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (elig[wrap_add(rr_ptr_q, i)]) begin
        grant_val = 1'b1;
        grant_idx = wrap_add(rr_ptr_q, i);
      end
    end
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      req_rdy[k] = accept & (grant_idx == TAG_BITS'(k));
    end
  end

  always_comb begin
    mult_val_d = mult_val_q;
    mult_dat_d = mult_dat_q;
    mult_ctl_d = mult_ctl_q;
    rr_ptr_d   = rr_ptr_q;
    if (accept) begin
      mult_val_d = 1'b1;
      mult_dat_d = req_dat[grant_idx];
      mult_ctl_d = {grant_idx, req_ctl[grant_idx]};
      rr_ptr_d   = wrap_add(grant_idx, 1);
    end else if (out_free) begin
      mult_val_d = 1'b0;
    end

    rsp_val_d = rsp_val_q & ~rsp_taken;
    rsp_tag_d = rsp_tag_q;
    rsp_dat_d = rsp_dat_q;
    rsp_ctl_d = rsp_ctl_q;
    if (mult_fire & tag_ok) begin
      rsp_val_d = 1'b1;
      rsp_tag_d = mult_in_tag;
      rsp_dat_d = i_mult_if.dat[DAT_BITS-1:0];
      rsp_ctl_d = i_mult_if.ctl[CTL_BITS-1:0];
    end

    // A response for an idle requester is still delivered but flagged.
    err_d = (mult_fire & ~tag_ok) | (rsp_taken & (cnt_q[rsp_tag_q] == '0));

    cnt_zero = 1'b1;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      logic inc;
      logic dec;
      inc = accept & (grant_idx == TAG_BITS'(k));
      dec = rsp_taken & (rsp_tag_q == TAG_BITS'(k)) & (cnt_q[k] != '0);
      cnt_d[k] = cnt_q[k];
      if (inc & ~dec) begin
        cnt_d[k] = cnt_q[k] + CntOne;
      end else if (dec & ~inc) begin
        cnt_d[k] = cnt_q[k] - CntOne;
      end
      if (cnt_d[k] != '0) cnt_zero = 1'b0;
    end
    idle_d = cnt_zero & ~mult_val_d & ~rsp_val_d;
  end

  always_ff @(posedge i_clk) begin
    mult_dat_q <= mult_dat_d;
    mult_ctl_q <= mult_ctl_d;
    rsp_tag_q  <= rsp_tag_d;
    rsp_dat_q  <= rsp_dat_d;
    rsp_ctl_q  <= rsp_ctl_d;
    if (i_rst) begin
      mult_val_q <= 1'b0;
      rsp_val_q  <= 1'b0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
      idle_q     <= 1'b1;
      for (int k = 0; k < int'(NUM_REQ); k++) cnt_q[k] <= '0;
    end else begin
      mult_val_q <= mult_val_d;
      rsp_val_q  <= rsp_val_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
      idle_q     <= idle_d;
      for (int k = 0; k < int'(NUM_REQ); k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign o_mult_if.val = mult_val_q;
  assign o_mult_if.dat = mult_dat_q;
  assign o_mult_if.ctl = mult_ctl_q;
  assign o_mult_if.sop = 1'b1;
  assign o_mult_if.eop = 1'b1;
  assign o_mult_if.err = 1'b0;
  assign o_mult_if.mod = '0;
  assign i_mult_if.rdy = mult_in_rdy;
  assign o_idle        = idle_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_ec_fp_mult_arbiter.sv
// Directed bench for ec_fp_mult_arbiter: three requesters, MAX_OUT=2, bench acts
// as the multiplier by hand.
module tb_ec_fp_mult_arbiter;
  localparam int unsigned NR  = 3;
  localparam int unsigned DW  = 16;
  localparam int unsigned CW  = 8;
  localparam int unsigned MCW = CW + 2;

  logic clk;
  logic rst;
  logic o_idle;
  logic o_err;
  int   checks = 0;
  int   errors = 0;

  ec_fp_mult_arbiter_if #(.DAT_BITS(2*DW), .CTL_BITS(CW))  req_if [NR] ();
  ec_fp_mult_arbiter_if #(.DAT_BITS(DW),   .CTL_BITS(CW))  rsp_if [NR] ();
  ec_fp_mult_arbiter_if #(.DAT_BITS(2*DW), .CTL_BITS(MCW)) mult_o ();
  ec_fp_mult_arbiter_if #(.DAT_BITS(DW),   .CTL_BITS(MCW)) mult_i ();

  ec_fp_mult_arbiter #(
    .NUM_REQ (NR),
    .DAT_BITS(DW),
    .CTL_BITS(CW),
    .MAX_OUT (2)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_req_if (req_if),
    .o_rsp_if (rsp_if),
    .o_mult_if(mult_o),
    .i_mult_if(mult_i),
    .o_idle   (o_idle),
    .o_err    (o_err)
  );

  for (genvar g = 0; g < NR; g++) begin : g_const
    assign req_if[g].sop = 1'b1;
    assign req_if[g].eop = 1'b1;
    assign req_if[g].err = 1'b0;
    assign req_if[g].mod = '0;
  end
  assign mult_i.sop = 1'b1;
  assign mult_i.eop = 1'b1;
  assign mult_i.err = 1'b0;
  assign mult_i.mod = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req_if[0].val = 1'b0; req_if[0].dat = '0; req_if[0].ctl = '0;
    req_if[1].val = 1'b0; req_if[1].dat = '0; req_if[1].ctl = '0;
    req_if[2].val = 1'b0; req_if[2].dat = '0; req_if[2].ctl = '0;
    rsp_if[0].rdy = 1'b1;
    rsp_if[1].rdy = 1'b1;
    rsp_if[2].rdy = 1'b1;
    mult_o.rdy = 1'b1;
    mult_i.val = 1'b0; mult_i.dat = '0; mult_i.ctl = '0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_idle", o_idle, 1);
    chk("rst_mval", mult_o.val, 0);
    chk("rst_err", o_err, 0);
    chk("rst_rsp0", rsp_if[0].val, 0);
    chk("rst_cnt0", dut.cnt_q[0], 0);
    chk("rst_mirdy", mult_i.rdy, 1);

    // Single request from req0, 3*5 returned by the bench multiplier.
    req_if[0].val = 1'b1; req_if[0].dat = {16'd5, 16'd3}; req_if[0].ctl = 8'h05;
    #1 chk("t1_rdy0", req_if[0].rdy, 1);
    tick();
    req_if[0].val = 1'b0;
    chk("t1_mval", mult_o.val, 1);
    chk("t1_mctl", mult_o.ctl, 10'h005);
    chk("t1_mdat", mult_o.dat, 32'h0005_0003);
    chk("t1_cnt", dut.cnt_q[0], 1);
    tick();
    chk("t1_mdrain", mult_o.val, 0);
    mult_i.val = 1'b1; mult_i.dat = 16'd15; mult_i.ctl = 10'h005;
    #1 chk("t1_mirdy", mult_i.rdy, 1);
    tick();
    mult_i.val = 1'b0;
    chk("t1_rval", rsp_if[0].val, 1);
    chk("t1_rdat", rsp_if[0].dat, 16'd15);
    chk("t1_rctl", rsp_if[0].ctl, 8'h05);
    chk("t1_r1val", rsp_if[1].val, 0);
    chk("t1_r2val", rsp_if[2].val, 0);
    tick();
    chk("t1_cnt0", dut.cnt_q[0], 0);
    chk("t1_rdone", rsp_if[0].val, 0);
    chk("t1_idle", o_idle, 1);
    chk("t1_err", o_err, 0);

    // Alternating grants, bench echoes each multiply straight back.
    do_reset();
    req_if[0].val = 1'b1; req_if[0].ctl = 8'h10; req_if[0].dat = 32'h1;
    req_if[1].val = 1'b1; req_if[1].ctl = 8'h11; req_if[1].dat = 32'h2;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t2_mval", mult_o.val, 1);
      chk("t2_tag", mult_o.ctl[9:8], 64'(i % 2));
      chk("t2_ctl", mult_o.ctl[7:0], (i % 2 == 1) ? 64'h11 : 64'h10);
      if (i > 0) begin
        if (i % 2 == 1) begin
          chk("t2_rsp0", rsp_if[0].val, 1);
          chk("t2_rsp0d", rsp_if[0].dat, 64'(i - 1));
        end else begin
          chk("t2_rsp1", rsp_if[1].val, 1);
          chk("t2_rsp1d", rsp_if[1].dat, 64'(i - 1));
        end
      end
      mult_i.val = 1'b1; mult_i.ctl = mult_o.ctl; mult_i.dat = 16'(i);
    end
    req_if[0].val = 1'b0;
    req_if[1].val = 1'b0;
    tick();
    mult_i.val = 1'b0;
    tick();
    tick();
    chk("t2_idle", o_idle, 1);
    chk("t2_cnt0", dut.cnt_q[0], 0);
    chk("t2_cnt1", dut.cnt_q[1], 0);

    // Output backpressure holds the registered request.
    do_reset();
    mult_o.rdy = 1'b0;
    req_if[0].val = 1'b1; req_if[0].dat = 32'hAAAA_0001; req_if[0].ctl = 8'h33;
    tick();
    req_if[0].dat = 32'hBBBB_0002; req_if[0].ctl = 8'h44;
    req_if[1].val = 1'b1; req_if[1].dat = 32'hCCCC_0003; req_if[1].ctl = 8'h55;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t3_mval", mult_o.val, 1);
      chk("t3_dat", mult_o.dat, 32'hAAAA_0001);
      chk("t3_ctl", mult_o.ctl, 10'h033);
      chk("t3_rdy0", req_if[0].rdy, 0);
      chk("t3_rdy1", req_if[1].rdy, 0);
      tick();
    end
    mult_o.rdy = 1'b1;
    #1;
    chk("t3_go_rdy1", req_if[1].rdy, 1);
    chk("t3_go_rdy0", req_if[0].rdy, 0);
    tick();
    chk("t3_next_ctl", mult_o.ctl, 10'h155);
    chk("t3_next_dat", mult_o.dat, 32'hCCCC_0003);
    req_if[0].val = 1'b0;
    req_if[1].val = 1'b0;
    tick();
    chk("t3_drain", mult_o.val, 0);

    // MAX_OUT=2 blocks req0 while req1 still gets through.
    do_reset();
    req_if[0].val = 1'b1; req_if[0].ctl = 8'h01; req_if[0].dat = 32'h1;
    tick();
    tick();
    chk("t4_cnt2", dut.cnt_q[0], 2);
    req_if[1].val = 1'b1; req_if[1].ctl = 8'h02; req_if[1].dat = 32'h2;
    #1;
    chk("t4_blk0", req_if[0].rdy, 0);
    chk("t4_go1", req_if[1].rdy, 1);
    tick();
    chk("t4_ctl1", mult_o.ctl, 10'h102);
    req_if[1].val = 1'b0;
    #1 chk("t4_blk0b", req_if[0].rdy, 0);
    tick();
    chk("t4_nogrant", mult_o.val, 0);
    mult_i.val = 1'b1; mult_i.ctl = 10'h001; mult_i.dat = 16'h0007;
    tick();
    mult_i.val = 1'b0;
    chk("t4_rsp0", rsp_if[0].val, 1);
    chk("t4_blk0c", req_if[0].rdy, 0);
    tick();
    chk("t4_cnt1", dut.cnt_q[0], 1);
    chk("t4_unblk", req_if[0].rdy, 1);
    req_if[0].val = 1'b0;

    // Stalled consumer holds the response register, order preserved.
    do_reset();
    rsp_if[1].rdy = 1'b0;
    mult_i.val = 1'b1; mult_i.ctl = 10'h121; mult_i.dat = 16'h1111;
    tick();
    mult_i.ctl = 10'h022; mult_i.dat = 16'h2222;
    #1;
    chk("t5_mirdy0", mult_i.rdy, 0);
    chk("t5_r1val", rsp_if[1].val, 1);
    chk("t5_r1dat", rsp_if[1].dat, 16'h1111);
    chk("t5_r1ctl", rsp_if[1].ctl, 8'h21);
    chk("t5_r0val", rsp_if[0].val, 0);
    tick();
    tick();
    chk("t5_hold_dat", rsp_if[1].dat, 16'h1111);
    chk("t5_hold_val", rsp_if[1].val, 1);
    chk("t5_hold_rdy", mult_i.rdy, 0);
    chk("t5_hold_r0", rsp_if[0].val, 0);
    rsp_if[1].rdy = 1'b1;
    #1 chk("t5_mirdy1", mult_i.rdy, 1);
    tick();
    mult_i.val = 1'b0;
    chk("t5_r0val2", rsp_if[0].val, 1);
    chk("t5_r0dat", rsp_if[0].dat, 16'h2222);
    chk("t5_r0ctl", rsp_if[0].ctl, 8'h22);
    chk("t5_r1gone", rsp_if[1].val, 0);
    chk("t5_uflow1", o_err, 1);
    chk("t5_cnt1", dut.cnt_q[1], 0);
    tick();
    chk("t5_uflow0", o_err, 1);
    chk("t5_r0gone", rsp_if[0].val, 0);
    chk("t5_cnt0", dut.cnt_q[0], 0);
    tick();
    chk("t5_errclr", o_err, 0);

    // Invalid tag, then reset in the middle of traffic.
    do_reset();
    req_if[0].val = 1'b1; req_if[0].ctl = 8'h06; req_if[0].dat = 32'h6;
    tick();
    req_if[0].val = 1'b0;
    chk("t6_cnt0", dut.cnt_q[0], 1);
    tick();
    mult_i.val = 1'b1; mult_i.ctl = 10'h366; mult_i.dat = 16'h0009;
    #1 chk("t6_mirdy", mult_i.rdy, 1);
    tick();
    mult_i.val = 1'b0;
    chk("t6_err", o_err, 1);
    chk("t6_r0", rsp_if[0].val, 0);
    chk("t6_r1", rsp_if[1].val, 0);
    chk("t6_r2", rsp_if[2].val, 0);
    chk("t6_cnt0b", dut.cnt_q[0], 1);
    chk("t6_cnt1", dut.cnt_q[1], 0);
    tick();
    chk("t6_errpulse", o_err, 0);
    chk("t6_cnt0c", dut.cnt_q[0], 1);
    mult_o.rdy = 1'b0;
    rsp_if[1].rdy = 1'b0;
    req_if[0].val = 1'b1; req_if[0].ctl = 8'h07;
    mult_i.val = 1'b1; mult_i.ctl = 10'h108; mult_i.dat = 16'h0005;
    tick();
    chk("t6_busy_m", mult_o.val, 1);
    chk("t6_busy_r", rsp_if[1].val, 1);
    chk("t6_busy_idle", o_idle, 0);
    chk("t6_busy_cnt", dut.cnt_q[0], 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_m", mult_o.val, 0);
    chk("t6_rst_r0", rsp_if[0].val, 0);
    chk("t6_rst_r1", rsp_if[1].val, 0);
    chk("t6_rst_r2", rsp_if[2].val, 0);
    chk("t6_rst_idle", o_idle, 1);
    chk("t6_rst_err", o_err, 0);
    chk("t6_rst_cnt", dut.cnt_q[0], 0);
    clr();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
